// File: rtl/hpi_responder.sv
`default_nettype none
// ============================================================================
// hpi_responder : host-port responder with word memory, mailboxes and status
// Option: define HPI_RESP_AUTOINC_EN to post-increment ADDRESS on DATA access
// Revision: 1.0
// ============================================================================
module hpi_responder #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  hpi_addr,
  input  logic        hpi_cs_n,
  input  logic        hpi_rd_n,
  input  logic        hpi_wr_n,
  input  logic [15:0] hpi_data_in,
  output logic [15:0] hpi_data_out,
  output logic        hpi_data_oe,
  output logic [15:0] mbx_in_data,
  output logic        mbx_in_valid,
  input  logic        mbx_in_ack,
  input  logic [15:0] mbx_out_data,
  input  logic        mbx_out_wr,
  output logic        hpi_irq
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MBX  = 2'd1;
  localparam logic [1:0] A_ADDR = 2'd2;
`ifdef HPI_RESP_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RD, WR, ERR} state_t;

  state_t        state_q, state_d;
  logic [15:0]   ptr_q, ptr_d;
  logic [15:0]   dout_q, dout_d;
  logic [15:0]   mbx_in_q, mbx_in_d;
  logic [15:0]   mbx_out_q, mbx_out_d;
  logic [1:0]    acc_addr_q, acc_addr_d;
  logic          in_full_q, in_full_d;
  logic          out_full_q, out_full_d;
  logic          err_q, err_d;
  logic          armed_q, armed_d;
  logic          mem_we;
  logic [1:0]    rd_sel;
  logic [15:0]   rd_word;
  logic [AW-1:0] mem_idx;
  logic [15:0]   mem [MEM_WORDS];

  assign mem_idx = ptr_q[AW:1];

  // On the entry edge the live address selects; afterwards the latched one.
  always_comb begin
    rd_sel = (state_q == IDLE) ? hpi_addr : acc_addr_q;
    case (rd_sel)
      A_DATA:  rd_word = mem[mem_idx];
      A_MBX:   rd_word = mbx_out_q;
      A_ADDR:  rd_word = ptr_q;
      default: rd_word = {err_q, 13'b0, out_full_q, in_full_q};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    dout_d     = dout_q;
    mbx_in_d   = mbx_in_q;
    mbx_out_d  = mbx_out_q;
    acc_addr_d = acc_addr_q;
    in_full_d  = in_full_q;
    out_full_d = out_full_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    // An access already underway when reset lifts is ignored until the bus idles.
    armed_d    = armed_q | hpi_cs_n | (hpi_rd_n & hpi_wr_n);
    if (mbx_in_ack) in_full_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (armed_q && !hpi_cs_n) begin
          acc_addr_d = hpi_addr;
          if (!hpi_rd_n && !hpi_wr_n) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else if (!hpi_rd_n) begin
            state_d = RD;
            dout_d  = rd_word;
          end else if (!hpi_wr_n) begin
            state_d = WR;
            case (hpi_addr)
              A_DATA:  mem_we = 1'b1;
              A_MBX: begin
                mbx_in_d  = hpi_data_in;
                in_full_d = 1'b1;
              end
              A_ADDR:  ptr_d = hpi_data_in;
              default: if (hpi_data_in[15]) err_d = 1'b0;
            endcase
          end
        end
      end
      RD: begin
        dout_d = rd_word;
        if (hpi_cs_n || hpi_rd_n) begin
          state_d = IDLE;
          if (acc_addr_q == A_MBX) out_full_d = 1'b0;
          if (AUTOINC && acc_addr_q == A_DATA) ptr_d = ptr_q + 16'd2;
        end
      end
      WR: begin
        if (hpi_cs_n || hpi_wr_n) begin
          state_d = IDLE;
          if (AUTOINC && acc_addr_q == A_DATA) ptr_d = ptr_q + 16'd2;
        end
      end
      default: begin
        if (hpi_cs_n || (hpi_rd_n && hpi_wr_n)) state_d = IDLE;
      end
    endcase

    // A fresh outbound post overrides the clear from a mailbox read exit.
    if (mbx_out_wr) begin
      mbx_out_d  = mbx_out_data;
      out_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= 16'h0000;
      dout_q     <= 16'h0000;
      mbx_in_q   <= 16'h0000;
      mbx_out_q  <= 16'h0000;
      acc_addr_q <= 2'd0;
      in_full_q  <= 1'b0;
      out_full_q <= 1'b0;
      err_q      <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      dout_q     <= dout_d;
      mbx_in_q   <= mbx_in_d;
      mbx_out_q  <= mbx_out_d;
      acc_addr_q <= acc_addr_d;
      in_full_q  <= in_full_d;
      out_full_q <= out_full_d;
      err_q      <= err_d;
      armed_q    <= armed_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= hpi_data_in;
  end

  assign hpi_data_out = dout_q;
  assign hpi_data_oe  = (state_q == RD);
  assign mbx_in_data  = mbx_in_q;
  assign mbx_in_valid = in_full_q;
  assign hpi_irq      = out_full_q;

endmodule
`default_nettype wire

// File: tb/tb_hpi_responder.sv
`default_nettype none
// ============================================================================
// tb_hpi_responder : randomized scoreboard bench for hpi_responder
// Revision: 1.0
// ============================================================================
module tb_hpi_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  hpi_addr = 2'd0;
  logic        hpi_cs_n = 1'b1;
  logic        hpi_rd_n = 1'b1;
  logic        hpi_wr_n = 1'b1;
  logic [15:0] hpi_data_in = 16'h0;
  logic [15:0] hpi_data_out;
  logic        hpi_data_oe;
  logic [15:0] mbx_in_data;
  logic        mbx_in_valid;
  logic        mbx_in_ack = 1'b0;
  logic [15:0] mbx_out_data = 16'h0;
  logic        mbx_out_wr = 1'b0;
  logic        hpi_irq;

  always #5 clk = ~clk;

  hpi_responder #(.MEM_WORDS(256)) dut (
    .clk(clk), .reset(reset), .hpi_addr(hpi_addr), .hpi_cs_n(hpi_cs_n),
    .hpi_rd_n(hpi_rd_n), .hpi_wr_n(hpi_wr_n), .hpi_data_in(hpi_data_in),
    .hpi_data_out(hpi_data_out), .hpi_data_oe(hpi_data_oe),
    .mbx_in_data(mbx_in_data), .mbx_in_valid(mbx_in_valid), .mbx_in_ack(mbx_in_ack),
    .mbx_out_data(mbx_out_data), .mbx_out_wr(mbx_out_wr), .hpi_irq(hpi_irq)
  );

`ifdef HPI_RESP_AUTOINC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic [15:0] exp_q[$];

  // Reference model: register file as plain variables, memory as an array.
  logic [15:0] m_mem [256];
  bit          m_val [256];
  logic [15:0] m_ptr = 16'h0, m_in = 16'h0, m_out = 16'h0;
  bit          m_s0 = 0, m_s1 = 0, m_err = 0;

  function automatic int m_idx();
    return (int'(m_ptr) / 2) % 256;
  endfunction

  function automatic logic [15:0] m_status();
    return {m_err, 13'b0, m_s1, m_s0};
  endfunction

  function automatic void check(string nm, logic [15:0] act, logic [15:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [15:0] d, input bit ack_at_commit = 0);
    @(posedge clk); #1;
    hpi_addr = a; hpi_data_in = d; hpi_cs_n = 0; hpi_wr_n = 0;
    if (ack_at_commit) mbx_in_ack = 1;
    @(posedge clk); #1;
    mbx_in_ack = 0;
    hpi_data_in = 16'($urandom);
    @(posedge clk); #1;
    hpi_cs_n = 1; hpi_wr_n = 1;
    @(posedge clk); #1;
    case (a)
      2'd0: begin
        m_mem[m_idx()] = d;
        m_val[m_idx()] = 1;
        if (AUTO) m_ptr = m_ptr + 16'd2;
      end
      2'd1: begin m_in = d; m_s0 = 1; end
      2'd2: m_ptr = d;
      default: if (d[15]) m_err = 0;
    endcase
  endtask

  task automatic bus_read(input logic [1:0] a, input bit post = 0, input logic [15:0] pw = 16'h0);
    int hold;
    case (a)
      2'd0:    exp_q.push_back(m_mem[m_idx()]);
      2'd1:    exp_q.push_back(m_out);
      2'd2:    exp_q.push_back(m_ptr);
      default: exp_q.push_back(m_status());
    endcase
    hold = int'($urandom_range(2, 4));
    @(posedge clk); #1;
    hpi_addr = a; hpi_cs_n = 0; hpi_rd_n = 0;
    repeat (hold) @(posedge clk);
    #1;
    hpi_cs_n = 1; hpi_rd_n = 1;
    if (post) begin mbx_out_data = pw; mbx_out_wr = 1; end
    @(posedge clk); #1;
    mbx_out_wr = 0;
    check("oe_after_read", {15'b0, hpi_data_oe}, 16'h0);
    if (a == 2'd1) m_s1 = 0;
    if (a == 2'd0 && AUTO) m_ptr = m_ptr + 16'd2;
    if (post) begin m_out = pw; m_s1 = 1; end
  endtask

  task automatic pulse_ack();
    @(posedge clk); #1 mbx_in_ack = 1;
    @(posedge clk); #1 mbx_in_ack = 0;
    m_s0 = 0;
  endtask

  task automatic post_out(input logic [15:0] w);
    @(posedge clk); #1 mbx_out_data = w; mbx_out_wr = 1;
    @(posedge clk); #1 mbx_out_wr = 0;
    m_out = w; m_s1 = 1;
  endtask

  // Monitor: read data is compared on the second falling edge with oe high.
  initial begin
    int oe_run;
    oe_run = 0;
    forever begin
      @(negedge clk);
      if (hpi_data_oe === 1'b1) begin
        oe_run++;
        if (oe_run == 2) begin
          if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL rd_unexpected: got %h expected no read", hpi_data_out);
          end else begin
            check("rd_data", hpi_data_out, exp_q.pop_front());
          end
        end
      end else begin
        oe_run = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ra, rw, k;
    repeat (3) @(posedge clk);
    #1;
    check("rst_oe", {15'b0, hpi_data_oe}, 16'h0);
    check("rst_dout", hpi_data_out, 16'h0);
    check("rst_irq", {15'b0, hpi_irq}, 16'h0);
    check("rst_in_valid", {15'b0, mbx_in_valid}, 16'h0);
    check("rst_in_data", mbx_in_data, 16'h0);
    reset = 0;
    repeat (2) @(posedge clk);

    // Pointer-driven DATA writes and reads back.
    bus_write(2, 16'h0010);
    bus_write(0, 16'hAAAA);
    bus_write(0, 16'hBBBB);
    bus_read(2);
    bus_write(2, 16'h0010);
    bus_read(0);
    bus_read(0);

    // Pointer wrap and high address bits ignored.
    bus_write(2, 16'hFFFE);
    bus_write(0, 16'($urandom));
    bus_read(2);
    bus_write(2, 16'h0201);
    bus_write(0, 16'($urandom));
    bus_write(2, 16'h0000);
    bus_read(0);

    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom);
      rw = 16'($urandom);
      bus_write(2, ra);
      bus_write(0, rw);
      bus_write(2, ra);
      bus_read(0);
      if (i % 4 == 0) bus_read(2);
    end

    // Inbound mailbox.
    bus_write(1, 16'h1234);
    check("in_valid_set", {15'b0, mbx_in_valid}, {15'b0, m_s0});
    check("in_data", mbx_in_data, m_in);
    bus_read(3);
    pulse_ack();
    check("in_valid_clr", {15'b0, mbx_in_valid}, 16'h0);
    bus_read(3);
    rw = 16'($urandom);
    bus_write(1, rw, 1);
    check("ack_vs_write_valid", {15'b0, mbx_in_valid}, 16'h1);
    check("ack_vs_write_data", mbx_in_data, rw);
    pulse_ack();

    // Outbound mailbox.
    post_out(16'h5678);
    check("irq_set", {15'b0, hpi_irq}, 16'h1);
    bus_read(1);
    check("irq_clr", {15'b0, hpi_irq}, 16'h0);
    post_out(16'($urandom));
    bus_read(1, 1, 16'h9ABC);
    check("irq_set_wins", {15'b0, hpi_irq}, 16'h1);
    bus_read(1);
    check("irq_clr2", {15'b0, hpi_irq}, 16'h0);

    // Read/write collision: sticky error, nothing modified.
    bus_write(2, 16'h0040);
    bus_write(0, 16'h0F0F);
    bus_write(2, 16'h0040);
    @(posedge clk); #1;
    hpi_addr = 2'd0; hpi_data_in = 16'hDEAD; hpi_cs_n = 0; hpi_rd_n = 0; hpi_wr_n = 0;
    repeat (2) @(posedge clk);
    #1 hpi_rd_n = 1;
    repeat (2) @(posedge clk);
    #1 check("err_no_oe", {15'b0, hpi_data_oe}, 16'h0);
    hpi_cs_n = 1; hpi_wr_n = 1;
    @(posedge clk); #1;
    m_err = 1;
    bus_read(3);
    bus_read(2);
    bus_read(0);
    bus_write(3, 16'h7FFF);
    bus_read(3);
    bus_write(3, 16'h8000);
    bus_read(3);

    // Strobes without chip select are ignored.
    bus_write(2, 16'h0040);
    @(posedge clk); #1;
    hpi_addr = 2'd0; hpi_data_in = 16'hBEEF; hpi_wr_n = 0;
    repeat (2) @(posedge clk);
    #1 hpi_wr_n = 1; hpi_rd_n = 0;
    repeat (2) @(posedge clk);
    #1 check("no_cs_oe", {15'b0, hpi_data_oe}, 16'h0);
    hpi_rd_n = 1;
    bus_read(0);

    // Reset in the middle of a write.
    k = 16'($urandom);
    bus_write(2, 16'h0000);
    bus_write(0, k);
    post_out(16'h1111);
    bus_write(1, 16'h2222);
    bus_write(2, 16'hFFFE);
    @(posedge clk); #1;
    hpi_addr = 2'd0; hpi_data_in = 16'h3333; hpi_cs_n = 0; hpi_wr_n = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    #1;
    check("rst_mid_oe", {15'b0, hpi_data_oe}, 16'h0);
    check("rst_mid_irq", {15'b0, hpi_irq}, 16'h0);
    check("rst_mid_valid", {15'b0, mbx_in_valid}, 16'h0);
    check("rst_mid_in_data", mbx_in_data, 16'h0);
    @(posedge clk); #1;
    reset = 0;
    hpi_data_in = 16'h4444;
    repeat (3) @(posedge clk);
    #1 hpi_cs_n = 1; hpi_wr_n = 1;
    @(posedge clk); #1;
    m_ptr = 16'h0; m_in = 16'h0; m_out = 16'h0;
    m_s0 = 0; m_s1 = 0; m_err = 0;
    m_val[255] = 0;
    bus_read(2);
    bus_read(3);
    bus_read(0);
    bus_read(2);
    bus_read(1);

    repeat (5) @(posedge clk);
    chk_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL reads_pending: got %0d expected 0", exp_q.size());
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
